mcr3_rom_loader: RTL and testbench
==================================

# mcr3_rom_loader

Sequences the HPS ROM download stream into the MCR3 memory system. Sits between `hps_io` and the `sdram` controller / `Tapper` core. Decodes each downloaded byte by index and address into SDRAM port1 (CPU ROM image), SDRAM port2 (sprite ROMs, per-game lane mapping) and the core's background/char loader. Runs the toggle req/ack handshakes, throttles the HPS with `ioctl_wait`, latches the game-select byte and generates the core reset sequence.

## Interface
- `DL_BASE`, default 25'h32000: first address of background/char graphics.
- `HOLD_CYCLES`, default 16'hFFFF: post-load reset hold count.
- `clk_sys` in 1: 40 MHz system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rst_req` in 1: OR of board reset, OSD reset and button reset.
- `ioctl_download`, `ioctl_wr` in 1; `ioctl_index` in 8; `ioctl_addr` in 25; `ioctl_dout` in 8: HPS download stream.
- `ioctl_wait` out 1: stall request to HPS.
- `port1_req` out 1, `port1_ack` in 1, `port1_a` out 23, `port1_ds` out 2, `port1_d` out 16, `port1_we` out 1.
- `port2_req` out 1, `port2_ack` in 1, `port2_a` out 23, `port2_ds` out 2, `port2_d` out 16, `port2_we` out 1.
- `dl_wr` out 1, `dl_addr` out 25, `dl_data` out 8: core graphics loader.
- `game` out 2: 0 tapper, 1 timber, 2 dotron, 3 demoderb.
- `rom_loaded` out 1; `core_reset` out 1 (active-high); `overrun` out 1 (sticky).

## Operation
- Index 1 write: `game <= ioctl_dout[1:0]`. No SDRAM traffic.
- Index 0 write: a byte is captured on the rising edge of `ioctl_wr`. The cycle before must have had `ioctl_wr` low or a different index.
- Port1 handling:
  - Every captured byte goes to port1 with `a=addr[23:1]`, `ds={addr[0],~addr[0]}` and `d={dout,dout}`.
  - `port1_we = ioctl_download`.
- Port2 handling:
  - Covers bytes in `[SP_BASE(game), DL_BASE)`.
  - SP_BASE: tapper 0x12000, timber 0x11000, dotron 0x12000, demoderb 0x14000.
  - `s = addr - SP_BASE`.
  - `a`: tapper/timber `{s[18:17],s[14:0],s[16]}`; dotron `{s[13:0],s[15]}`; demoderb `{s[14:0],s[16]}`. Each is zero-extended to 23 bits.
  - `ds`: dotron `{s[14],~s[14]}`; all others `{s[15],~s[15]}`.
- Background/char bytes:
  - Bytes with `addr >= DL_BASE` pulse `dl_wr` for one cycle.
  - `dl_addr = addr - DL_BASE`.
- Per-port FSM: IDLE → ISSUE (toggle `req`) → WAIT (until `ack == req`) → IDLE. A port not targeted by the byte stays IDLE.
- `ioctl_wait` is high while either port is in ISSUE or WAIT.
- Capture edge while any port is busy:
  - The byte is dropped.
  - `overrun <= 1`.
  - No req toggles.
- Download end: `rom_loaded <= 1` on the falling edge of registered `ioctl_download`. It stays 1 until `reset_n`.
- Reset counter:
  - Loads HOLD_CYCLES while `rst_req | ~rom_loaded`, otherwise decrements to 0 and holds.
  - `core_reset = rst_req | ~rom_loaded | (cnt == 1)`, registered. This gives a second one-cycle reset pulse HOLD_CYCLES-1 cycles after release.

## Timing
- Reset (`reset_n`=0) values:
  - all req 0;
  - FSMs IDLE;
  - `game` 0, `rom_loaded` 0, `overrun` 0;
  - `dl_wr` 0, `ioctl_wait` 0;
  - `core_reset` 1, counter HOLD_CYCLES;
  - address/data outputs 0.
- Capture at edge cycle T:
  - `port*_a/ds/d` valid at T+1, same cycle as the `req` toggle.
  - `ioctl_wait` high from T+1.
  - `dl_wr` high at T+1 only.
- `ioctl_wait` falls the cycle after the last `ack == req` is registered. If ack arrives in the same cycle as the toggle, the port spends one WAIT cycle.
- Address/data outputs hold stable from ISSUE until return to IDLE.
- Simultaneous index-1 write and busy: `game` updates immediately. In-flight port2 mapping uses the value captured at T.
- `reset_n` mid-transfer: handshake abandoned. The sdram controller must be reset in the same domain.

## Structure
- Package `mcr3_pkg`: `game_t` enum, SP_BASE per game, DL_BASE default, port FSM state enum.
- One sub-module `toggle_port_ctl` (IDLE/ISSUE/WAIT, req/ack/busy), instantiated for port1 and port2.

## Test plan
- Tapper, byte 0xA5 at 0x00123 → port1 `a=0x91`, `ds=2'b10`, `d=0xA5A5`, one req toggle; port2 idle; `ioctl_wait` clears after ack.
- Tapper, byte at 0x1A001 (s=0x8001) → port2 `a={2'b00,0x0001,1'b0}=0x2`, `ds=2'b10`; port1 also toggles.
- Dotron, byte at 0x16000 (s=0x4000) → port2 `a=0x0`, `ds=2'b10`; demoderb at 0x24000 (s=0x10000) → `a=0x1`, `ds=2'b01`.
- Byte at 0x32010 → `dl_wr` one cycle, `dl_addr=0x10`, `dl_data` matches; second edge with ack withheld → `overrun=1`, no extra toggle.
- Download ends with HOLD_CYCLES=16 → `rom_loaded=1`; `core_reset` low 14 cycles later, high exactly one cycle, then low; `rst_req` pulse reloads.
- `reset_n` asserted during WAIT → all outputs at reset values next edge; `game` returns to 0.

Source files
------------

// File: rtl/mcr3_pkg.sv
// rtl/mcr3_pkg.sv - shared types, address map and sprite lane mapping for the MCR3 ROM loader
package mcr3_pkg;

  typedef enum logic [1:0] {
    GAME_TAPPER   = 2'd0,
    GAME_TIMBER   = 2'd1,
    GAME_DOTRON   = 2'd2,
    GAME_DEMODERB = 2'd3
  } game_t;

  localparam logic [24:0] DL_BASE_DEFAULT = 25'h32000;

  typedef logic [1:0] port_state_t;
  localparam port_state_t PS_IDLE  = 2'd0;
  localparam port_state_t PS_ISSUE = 2'd1;
  localparam port_state_t PS_WAIT  = 2'd2;

  function automatic logic [24:0] sp_base(input game_t g);
    case (g)
      GAME_TIMBER:   return 25'h11000;
      GAME_DEMODERB: return 25'h14000;
      default:       return 25'h12000;
    endcase
  endfunction

  // Returns {ds, a} for a sprite byte at offset s from the game's sprite base.
  function automatic logic [24:0] port2_map(input game_t g, input logic [24:0] s);
    logic [22:0] a;
    logic [1:0]  ds;
    case (g)
      GAME_DOTRON: begin
        a  = {8'd0, s[13:0], s[15]};
        ds = {s[14], ~s[14]};
      end
      GAME_DEMODERB: begin
        a  = {7'd0, s[14:0], s[16]};
        ds = {s[15], ~s[15]};
      end
      default: begin
        a  = {5'd0, s[18:17], s[14:0], s[16]};
        ds = {s[15], ~s[15]};
      end
    endcase
    return {ds, a};
  endfunction

endpackage

// File: rtl/toggle_port_ctl.sv
// rtl/toggle_port_ctl.sv - toggle req/ack handshake sequencer for one SDRAM port
module toggle_port_ctl
  import mcr3_pkg::*;
(
  input  logic clk_sys,
  input  logic reset_n,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic busy
);

  port_state_t state;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= PS_IDLE;
      req   <= 1'b0;
    end else begin
      case (state)
        PS_IDLE: begin
          if (start) begin
            req   <= ~req;
            state <= PS_ISSUE;
          end
        end
        PS_ISSUE: state <= PS_WAIT;
        PS_WAIT:  if (ack == req) state <= PS_IDLE;
        default:  state <= PS_IDLE;
      endcase
    end
  end

  assign busy = (state != PS_IDLE);

endmodule

// File: rtl/mcr3_rom_loader.sv
// rtl/mcr3_rom_loader.sv - routes HPS ROM download bytes to SDRAM ports and the graphics loader
module mcr3_rom_loader
  import mcr3_pkg::*;
#(
  parameter logic [24:0] DL_BASE     = DL_BASE_DEFAULT,
  parameter logic [15:0] HOLD_CYCLES = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        rst_req,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        dl_wr,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic [1:0]  game,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overrun
);

  game_t       game_q;
  logic        prev_wr0;
  logic        download_q;
  logic [15:0] cnt;
  logic        p1_busy, p2_busy, busy;
  logic        cap_edge, accept, p2_hit, dl_hit;
  logic [24:0] sp, s, p2_map;

  assign cap_edge = ioctl_wr && (ioctl_index == 8'd0) && !prev_wr0;
  assign busy     = p1_busy | p2_busy;
  assign accept   = cap_edge && !busy;

  assign sp     = sp_base(game_q);
  assign s      = ioctl_addr - sp;
  assign p2_map = port2_map(game_q, s);
  assign p2_hit = (ioctl_addr >= sp) && (ioctl_addr < DL_BASE);
  assign dl_hit = (ioctl_addr >= DL_BASE);

  toggle_port_ctl u_port1 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .start   (accept),
    .ack     (port1_ack),
    .req     (port1_req),
    .busy    (p1_busy)
  );

  toggle_port_ctl u_port2 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .start   (accept && p2_hit),
    .ack     (port2_ack),
    .req     (port2_req),
    .busy    (p2_busy)
  );

  assign ioctl_wait = busy;
  assign game       = game_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      game_q     <= GAME_TAPPER;
      prev_wr0   <= 1'b0;
      overrun    <= 1'b0;
      port1_a    <= '0;
      port1_ds   <= '0;
      port1_d    <= '0;
      port1_we   <= 1'b0;
      port2_a    <= '0;
      port2_ds   <= '0;
      port2_d    <= '0;
      port2_we   <= 1'b0;
      dl_wr      <= 1'b0;
      dl_addr    <= '0;
      dl_data    <= '0;
      download_q <= 1'b0;
      rom_loaded <= 1'b0;
      cnt        <= HOLD_CYCLES;
      core_reset <= 1'b1;
    end else begin
      prev_wr0 <= ioctl_wr && (ioctl_index == 8'd0);
      if (ioctl_wr && (ioctl_index == 8'd1)) game_q <= game_t'(ioctl_dout[1:0]);

      dl_wr <= 1'b0;
      if (cap_edge && busy) overrun <= 1'b1;
      // Address/data only load on an accepted byte, so they stay put for the whole handshake.
      if (accept) begin
        port1_a  <= ioctl_addr[23:1];
        port1_ds <= {ioctl_addr[0], ~ioctl_addr[0]};
        port1_d  <= {ioctl_dout, ioctl_dout};
        port1_we <= ioctl_download;
        if (p2_hit) begin
          port2_a  <= p2_map[22:0];
          port2_ds <= p2_map[24:23];
          port2_d  <= {ioctl_dout, ioctl_dout};
          port2_we <= ioctl_download;
        end
        if (dl_hit) begin
          dl_wr   <= 1'b1;
          dl_addr <= ioctl_addr - DL_BASE;
          dl_data <= ioctl_dout;
        end
      end

      download_q <= ioctl_download;
      if (download_q && !ioctl_download) rom_loaded <= 1'b1;

      if (rst_req || !rom_loaded) cnt <= HOLD_CYCLES;
      else if (cnt != 16'd0)      cnt <= cnt - 16'd1;
      core_reset <= rst_req || !rom_loaded || (cnt == 16'd1);
    end
  end

endmodule

// File: tb/tb_mcr3_rom_loader.sv
// tb/tb_mcr3_rom_loader.sv - directed self-checking bench for mcr3_rom_loader
module tb_mcr3_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        rst_req;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        port1_req, port1_ack, port1_we;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack, port2_we;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic [1:0]  game;
  logic        rom_loaded, core_reset, overrun;

  int passed = 0;
  int total  = 0;

  always #5 clk_sys = ~clk_sys;

  mcr3_rom_loader #(.DL_BASE(25'h32000), .HOLD_CYCLES(16'd16)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .rst_req        (rst_req),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .port1_req      (port1_req),
    .port1_ack      (port1_ack),
    .port1_a        (port1_a),
    .port1_ds       (port1_ds),
    .port1_d        (port1_d),
    .port1_we       (port1_we),
    .port2_req      (port2_req),
    .port2_ack      (port2_ack),
    .port2_a        (port2_a),
    .port2_ds       (port2_ds),
    .port2_d        (port2_d),
    .port2_we       (port2_we),
    .dl_wr          (dl_wr),
    .dl_addr        (dl_addr),
    .dl_data        (dl_data),
    .game           (game),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset),
    .overrun        (overrun)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic write_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl_index = 8'd0;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
  endtask

  task automatic set_game(input logic [1:0] g);
    ioctl_index = 8'd1;
    ioctl_dout  = {6'd0, g};
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd0;
  endtask

  task automatic ack_all();
    port1_ack = port1_req;
    port2_ack = port2_req;
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0; rst_req = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = 8'd0;
    port1_ack = 1'b0; port2_ack = 1'b0;
    tick(); tick();
    chk("rst_p1_req", 32'(port1_req), 32'd0);
    chk("rst_p2_req", 32'(port2_req), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_rom_loaded", 32'(rom_loaded), 32'd0);
    chk("rst_p1_a", 32'(port1_a), 32'd0);
    reset_n = 1'b1;
    ioctl_download = 1'b1;
    tick();

    // Tapper, CPU ROM byte: port1 only; ack already equal during ISSUE gives one WAIT cycle
    write_byte(25'h00123, 8'hA5);
    chk("t1_p1_req", 32'(port1_req), 32'd1);
    chk("t1_p1_a", 32'(port1_a), 32'h91);
    chk("t1_p1_ds", 32'(port1_ds), 32'd2);
    chk("t1_p1_d", 32'(port1_d), 32'hA5A5);
    chk("t1_p1_we", 32'(port1_we), 32'd1);
    chk("t1_p2_req", 32'(port2_req), 32'd0);
    chk("t1_wait", 32'(ioctl_wait), 32'd1);
    chk("t1_dl_wr", 32'(dl_wr), 32'd0);
    port1_ack = 1'b1;
    tick();
    chk("t1_wait_in_wait", 32'(ioctl_wait), 32'd1);
    tick();
    chk("t1_wait_clear", 32'(ioctl_wait), 32'd0);

    // Tapper sprite byte, s = 0x8001
    write_byte(25'h1A001, 8'h3C);
    chk("t2_p2_req", 32'(port2_req), 32'd1);
    chk("t2_p2_a", 32'(port2_a), 32'h2);
    chk("t2_p2_ds", 32'(port2_ds), 32'd2);
    chk("t2_p2_d", 32'(port2_d), 32'h3C3C);
    chk("t2_p1_req", 32'(port1_req), 32'd0);
    chk("t2_p1_a", 32'(port1_a), 32'hD000);
    ack_all();
    chk("t2_wait_clear", 32'(ioctl_wait), 32'd0);

    // Dotron, s = 0x4000
    set_game(2'd2);
    chk("t3_game", 32'(game), 32'd2);
    write_byte(25'h16000, 8'h11);
    chk("t3_p2_req", 32'(port2_req), 32'd0);
    chk("t3_p2_a", 32'(port2_a), 32'h0);
    chk("t3_p2_ds", 32'(port2_ds), 32'd2);
    ack_all();

    // Demoderb, s = 0x10000
    set_game(2'd3);
    write_byte(25'h24000, 8'h22);
    chk("t3b_p2_req", 32'(port2_req), 32'd1);
    chk("t3b_p2_a", 32'(port2_a), 32'h1);
    chk("t3b_p2_ds", 32'(port2_ds), 32'd1);
    chk("t3b_p1_a", 32'(port1_a), 32'h12000);
    ack_all();

    // Graphics byte, then a second edge while port1 is still waiting
    write_byte(25'h32010, 8'h5A);
    chk("t4_dl_wr", 32'(dl_wr), 32'd1);
    chk("t4_dl_addr", 32'(dl_addr), 32'h10);
    chk("t4_dl_data", 32'(dl_data), 32'h5A);
    chk("t4_p2_req_idle", 32'(port2_req), 32'd1);
    chk("t4_p1_req", 32'(port1_req), 32'd1);
    tick();
    chk("t4_dl_wr_pulse", 32'(dl_wr), 32'd0);
    chk("t4_no_overrun_yet", 32'(overrun), 32'd0);
    write_byte(25'h00200, 8'h77);
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_no_toggle", 32'(port1_req), 32'd1);
    chk("t4_p1_a_hold", 32'(port1_a), 32'h19008);
    chk("t4_wait_held", 32'(ioctl_wait), 32'd1);
    ack_all();
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Download end and reset sequencing with HOLD_CYCLES = 16
    ioctl_download = 1'b0;
    tick();
    chk("t5_rom_loaded", 32'(rom_loaded), 32'd1);
    chk("t5_core_reset_e0", 32'(core_reset), 32'd1);
    tick();
    chk("t5_core_reset_e1", 32'(core_reset), 32'd0);
    for (int i = 0; i < 14; i++) tick();
    chk("t5_core_reset_e15", 32'(core_reset), 32'd0);
    tick();
    chk("t5_core_reset_pulse", 32'(core_reset), 32'd1);
    tick();
    chk("t5_core_reset_e17", 32'(core_reset), 32'd0);
    tick(); tick();
    chk("t5_core_reset_hold", 32'(core_reset), 32'd0);
    rst_req = 1'b1;
    tick();
    chk("t5_rst_req_high", 32'(core_reset), 32'd1);
    rst_req = 1'b0;
    tick();
    chk("t5_rst_req_release", 32'(core_reset), 32'd0);

    // reset_n during WAIT
    ioctl_download = 1'b1;
    write_byte(25'h1A001, 8'h99);
    tick();
    chk("t6_busy_before", 32'(ioctl_wait), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_p1_req", 32'(port1_req), 32'd0);
    chk("t6_p2_req", 32'(port2_req), 32'd0);
    chk("t6_wait", 32'(ioctl_wait), 32'd0);
    chk("t6_game", 32'(game), 32'd0);
    chk("t6_rom_loaded", 32'(rom_loaded), 32'd0);
    chk("t6_overrun", 32'(overrun), 32'd0);
    chk("t6_core_reset", 32'(core_reset), 32'd1);
    chk("t6_p1_a", 32'(port1_a), 32'd0);
    chk("t6_p2_a", 32'(port2_a), 32'd0);
    port1_ack = 1'b0; port2_ack = 1'b0;
    tick();
    chk("t6_dl_wr", 32'(dl_wr), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
